ms5611_seq_ctrl: RTL and testbench



---
 rtl/ms5611_seq_ctrl_if.sv | 28 ++
 rtl/ms5611_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_ms5611_seq_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ms5611_seq_ctrl_if.sv
// Request/response handshake between the MS5611 sequencer and the shared serial bus master.
// The sequencer uses the master modport (it raises requests), the bus master uses slave.
interface ms5611_seq_ctrl_if;
   logic       Bus_Req;
   logic [7:0] Bus_Cmd;
   logic [1:0] Bus_Rd_Len;
   logic       Bus_Ack;
   logic       Bus_Done;
   logic       Bus_Err;

   modport master (
      output Bus_Req,
      output Bus_Cmd,
      output Bus_Rd_Len,
      input  Bus_Ack,
      input  Bus_Done,
      input  Bus_Err
   );

   modport slave (
      input  Bus_Req,
      input  Bus_Cmd,
      input  Bus_Rd_Len,
      output Bus_Ack,
      output Bus_Done,
      output Bus_Err
   );
endinterface

// File: rtl/ms5611_seq_ctrl.sv
// MS5611 sequencer: RESET, PROM burst, then periodic D2/D1 conversions with ADC reads.
// Every bus transaction retries on error; too many retries force a full re-initialisation.
module ms5611_seq_ctrl #(
   parameter int unsigned RST_CYCLES    = 150000,
   parameter int unsigned CONV_CYCLES   = 460000,
   parameter int unsigned PERIOD_CYCLES = 1000000,
   parameter int unsigned CAL_TIMEOUT   = 64,
   parameter int unsigned MAX_RETRY     = 3,
   parameter logic [7:0]  CMD_D1        = 8'h48,
   parameter logic [7:0]  CMD_D2        = 8'h58
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                En,
   ms5611_seq_ctrl_if.master   bus,
   output logic                Dat_Rdy,
   input  logic                Calib_Rdy,
   output logic                Busy,
   output logic                Err,
   output logic                Prom_Valid
);

   localparam int unsigned WAIT_M1  = (RST_CYCLES > CONV_CYCLES) ? RST_CYCLES : CONV_CYCLES;
   localparam int unsigned WAIT_MAX = (WAIT_M1 > CAL_TIMEOUT) ? WAIT_M1 : CAL_TIMEOUT;
   localparam int          WCNT_W   = $clog2(WAIT_MAX + 1);
   localparam int          FCNT_W   = $clog2(PERIOD_CYCLES + 1);
   localparam int          RCNT_W   = $clog2(MAX_RETRY + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RST_CMD, S_RST_WAIT, S_PROM_RD, S_PROM_RDY,
      S_D2_CMD, S_D2_WAIT, S_D2_RD, S_D1_CMD, S_D1_WAIT, S_D1_RD,
      S_DAT_RDY, S_CAL_WAIT, S_PERIOD_WAIT
   } state_t;

   state_t              r_state, w_state_next;
   logic                r_bus_req, w_bus_req_next;
   logic [7:0]          r_bus_cmd, w_bus_cmd_next;
   logic [1:0]          r_bus_len, w_bus_len_next;
   logic [WCNT_W-1:0]   r_wait_cnt, w_wait_cnt_next;
   logic [FCNT_W-1:0]   r_frame_cnt, w_frame_cnt_next;
   logic [RCNT_W-1:0]   r_retry, w_retry_next, w_retry_inc;
   logic [2:0]          r_prom_k, w_prom_k_next;
   logic                r_err, w_err_next;
   logic                r_prom_valid, w_prom_valid_next;
   logic                r_dat_rdy, r_busy;
   logic                w_issue, w_ack, w_done;

   // Command byte issued by each request state; PROM words sit at even addresses.
   function automatic logic [7:0] cmd_for(input state_t s, input logic [2:0] k);
      case (s)
         S_RST_CMD: cmd_for = 8'h1E;
         S_PROM_RD: cmd_for = 8'hA0 + {4'b0000, k, 1'b0};
         S_D2_CMD:  cmd_for = CMD_D2;
         S_D1_CMD:  cmd_for = CMD_D1;
         default:   cmd_for = 8'h00;
      endcase
   endfunction

   // Number of bytes the bus master reads back after the command.
   function automatic logic [1:0] len_for(input state_t s);
      case (s)
         S_PROM_RD:        len_for = 2'd2;
         S_D2_RD, S_D1_RD: len_for = 2'd3;
         default:          len_for = 2'd0;
      endcase
   endfunction

   assign w_ack       = r_bus_req & bus.Bus_Ack;
   // Done counts while waiting after an ack, or in the very cycle of the ack.
   assign w_done      = bus.Bus_Done & (w_ack | ~r_bus_req);
   assign w_retry_inc = r_retry + 1'b1;

   // Next-state, handshake and counter logic.
   always_comb begin
      w_state_next      = r_state;
      w_issue           = 1'b0;
      w_bus_req_next    = r_bus_req;
      w_bus_cmd_next    = r_bus_cmd;
      w_bus_len_next    = r_bus_len;
      w_wait_cnt_next   = r_wait_cnt;
      w_retry_next      = r_retry;
      w_prom_k_next     = r_prom_k;
      w_err_next        = r_err;
      w_prom_valid_next = r_prom_valid;
      w_frame_cnt_next  = (r_frame_cnt == '0) ? r_frame_cnt : r_frame_cnt - 1'b1;

      if (w_ack) begin
         w_bus_req_next = 1'b0;
      end
      // The ack cycle is the first cycle of the frame, so the next D2 request
      // rises exactly PERIOD_CYCLES cycles after this ack.
      if (w_ack && r_state == S_D2_CMD) begin
         w_frame_cnt_next = FCNT_W'(PERIOD_CYCLES - 1);
      end

      case (r_state)
         S_IDLE: begin
            if (En) begin
               w_state_next = S_RST_CMD;
               w_issue      = 1'b1;
            end
         end
         S_RST_CMD, S_PROM_RD, S_D2_CMD, S_D2_RD, S_D1_CMD, S_D1_RD: begin
            if (w_done) begin
               if (bus.Bus_Err) begin
                  if (32'(w_retry_inc) >= MAX_RETRY) begin
                     w_err_next        = 1'b1;
                     w_prom_valid_next = 1'b0;
                     w_retry_next      = '0;
                     w_state_next      = S_RST_CMD;
                  end else begin
                     w_retry_next = w_retry_inc;
                  end
                  w_issue = 1'b1;
               end else begin
                  w_retry_next = '0;
                  case (r_state)
                     S_RST_CMD: begin
                        w_state_next    = S_RST_WAIT;
                        w_wait_cnt_next = WCNT_W'(RST_CYCLES - 1);
                     end
                     S_PROM_RD: begin
                        if (r_prom_k == 3'd6) begin
                           w_state_next = S_PROM_RDY;
                        end else begin
                           w_prom_k_next = r_prom_k + 3'd1;
                           w_issue       = 1'b1;
                        end
                     end
                     S_D2_CMD: begin
                        w_state_next    = S_D2_WAIT;
                        w_wait_cnt_next = WCNT_W'(CONV_CYCLES - 1);
                     end
                     S_D2_RD: begin
                        w_state_next = S_D1_CMD;
                        w_issue      = 1'b1;
                     end
                     S_D1_CMD: begin
                        w_state_next    = S_D1_WAIT;
                        w_wait_cnt_next = WCNT_W'(CONV_CYCLES - 1);
                     end
                     default: begin
                        w_state_next = S_DAT_RDY;
                     end
                  endcase
               end
            end
         end
         S_RST_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_state_next  = S_PROM_RD;
               w_prom_k_next = 3'd0;
               w_issue       = 1'b1;
            end else begin
               w_wait_cnt_next = r_wait_cnt - 1'b1;
            end
         end
         S_PROM_RDY: begin
            w_prom_valid_next = 1'b1;
            w_state_next      = S_D2_CMD;
            w_issue           = 1'b1;
         end
         S_D2_WAIT, S_D1_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_state_next = (r_state == S_D2_WAIT) ? S_D2_RD : S_D1_RD;
               w_issue      = 1'b1;
            end else begin
               w_wait_cnt_next = r_wait_cnt - 1'b1;
            end
         end
         S_DAT_RDY: begin
            w_state_next    = S_CAL_WAIT;
            w_wait_cnt_next = WCNT_W'(CAL_TIMEOUT - 1);
         end
         S_CAL_WAIT: begin
            if (Calib_Rdy) begin
               w_state_next = S_PERIOD_WAIT;
            end else if (r_wait_cnt == '0) begin
               w_err_next   = 1'b1;
               w_state_next = S_PERIOD_WAIT;
            end else begin
               w_wait_cnt_next = r_wait_cnt - 1'b1;
            end
         end
         S_PERIOD_WAIT: begin
            // Leave on the edge where the frame counter reaches zero.
            if (r_frame_cnt <= FCNT_W'(1)) begin
               if (En) begin
                  w_state_next = S_D2_CMD;
                  w_issue      = 1'b1;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      if (w_issue) begin
         w_bus_req_next = 1'b1;
         w_bus_cmd_next = cmd_for(w_state_next, w_prom_k_next);
         w_bus_len_next = len_for(w_state_next);
      end
   end

   // State and registered outputs; asynchronous reset returns everything to idle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state      <= S_IDLE;
         r_bus_req    <= 1'b0;
         r_bus_cmd    <= 8'h00;
         r_bus_len    <= 2'd0;
         r_wait_cnt   <= '0;
         r_frame_cnt  <= '0;
         r_retry      <= '0;
         r_prom_k     <= 3'd0;
         r_err        <= 1'b0;
         r_prom_valid <= 1'b0;
         r_dat_rdy    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_bus_req    <= w_bus_req_next;
         r_bus_cmd    <= w_bus_cmd_next;
         r_bus_len    <= w_bus_len_next;
         r_wait_cnt   <= w_wait_cnt_next;
         r_frame_cnt  <= w_frame_cnt_next;
         r_retry      <= w_retry_next;
         r_prom_k     <= w_prom_k_next;
         r_err        <= w_err_next;
         r_prom_valid <= w_prom_valid_next;
         r_dat_rdy    <= (w_state_next == S_PROM_RDY) || (w_state_next == S_DAT_RDY);
         r_busy       <= !((w_state_next == S_IDLE) || (w_state_next == S_PERIOD_WAIT));
      end
   end

   assign bus.Bus_Req    = r_bus_req;
   assign bus.Bus_Cmd    = r_bus_cmd;
   assign bus.Bus_Rd_Len = r_bus_len;
   assign Dat_Rdy        = r_dat_rdy;
   assign Busy           = r_busy;
   assign Err            = r_err;
   assign Prom_Valid     = r_prom_valid;

endmodule

// File: tb/tb_ms5611_seq_ctrl.sv
// Directed bench for ms5611_seq_ctrl with a small bus-master and calibration model.
module tb_ms5611_seq_ctrl;

   typedef struct { logic [7:0] cmd; logic [1:0] len; } vec_t;
   typedef struct { logic [7:0] cmd; logic [1:0] len; int cyc; } ev_t;

   logic CLK = 1'b0;
   logic RSTn, En, Calib_Rdy, Dat_Rdy, Busy, Err, Prom_Valid;

   ms5611_seq_ctrl_if bus_if ();

   ms5611_seq_ctrl #(
      .RST_CYCLES(10), .CONV_CYCLES(20), .PERIOD_CYCLES(100),
      .CAL_TIMEOUT(8), .MAX_RETRY(3), .CMD_D1(8'h48), .CMD_D2(8'h58)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .En(En), .bus(bus_if), .Dat_Rdy(Dat_Rdy),
      .Calib_Rdy(Calib_Rdy), .Busy(Busy), .Err(Err), .Prom_Valid(Prom_Valid)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int overlap = 0;
   ev_t req_log[$];
   int ack_log[$];
   int done_log[$];
   int dat_log[$];
   logic [7:0] err_cmd = 8'h00;
   int err_left = 0;
   int cal_delay = 4;
   int cal_at = -1;
   logic m_active = 1'b0;
   int m_cnt = 0;
   logic [7:0] m_cmd = 8'h00;
   logic prev_req = 1'b0;
   vec_t vecs[23];

   // Bus master (ack 2 cycles, done 5 cycles after request), calibration echo, event log.
   always @(negedge CLK) begin
      if (!RSTn) begin
         m_active = 1'b0; m_cnt = 0; prev_req = 1'b0; cal_at = -1;
         bus_if.Bus_Ack = 1'b0; bus_if.Bus_Done = 1'b0; bus_if.Bus_Err = 1'b0;
         Calib_Rdy = 1'b0;
      end else begin
         bus_if.Bus_Ack = 1'b0; bus_if.Bus_Done = 1'b0; bus_if.Bus_Err = 1'b0;
         if (m_active) begin
            m_cnt++;
            if (m_cnt == 2) bus_if.Bus_Ack = 1'b1;
            if (m_cnt == 5) begin
               bus_if.Bus_Done = 1'b1;
               m_active = 1'b0;
               if (err_left > 0 && m_cmd == err_cmd) begin
                  bus_if.Bus_Err = 1'b1;
                  err_left--;
               end
            end
         end else if (bus_if.Bus_Req) begin
            m_active = 1'b1; m_cnt = 0; m_cmd = bus_if.Bus_Cmd;
         end
         Calib_Rdy = (cyc == cal_at);
         if (bus_if.Bus_Req && !prev_req)
            req_log.push_back('{bus_if.Bus_Cmd, bus_if.Bus_Rd_Len, cyc});
         prev_req = bus_if.Bus_Req;
         if (bus_if.Bus_Ack) ack_log.push_back(cyc);
         if (bus_if.Bus_Done) done_log.push_back(cyc);
         if (Dat_Rdy) begin
            dat_log.push_back(cyc);
            if (Prom_Valid && cal_delay > 0) cal_at = cyc + cal_delay;
         end
         if (Dat_Rdy && bus_if.Bus_Req) overlap++;
      end
      cyc++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic wait_reqs(input int n, input int budget, input string name);
      int k = 0;
      while (req_log.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check({name, "_reqs"}, req_log.size() >= n ? n : req_log.size(), n);
   endtask

   task automatic wait_dat(input int n, input int budget, input string name);
      int k = 0;
      while (dat_log.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check({name, "_datrdy"}, dat_log.size() >= n ? n : dat_log.size(), n);
   endtask

   task automatic check_req(input int i);
      if (i < req_log.size()) begin
         check($sformatf("req%0d_cmd", i), int'(req_log[i].cmd), int'(vecs[i].cmd));
         check($sformatf("req%0d_len", i), int'(req_log[i].len), int'(vecs[i].len));
         $display("req %0d: cmd=%02h len=%0d cyc=%0d", i, req_log[i].cmd, req_log[i].len, req_log[i].cyc);
      end else begin
         check($sformatf("req%0d_present", i), 0, 1);
      end
   endtask

   initial begin
      // Init (A4 fails once), two frames, then a frame whose D1 convert fails three times.
      vecs[0]  = '{8'h1E, 2'd0}; vecs[1]  = '{8'hA0, 2'd2}; vecs[2]  = '{8'hA2, 2'd2};
      vecs[3]  = '{8'hA4, 2'd2}; vecs[4]  = '{8'hA4, 2'd2}; vecs[5]  = '{8'hA6, 2'd2};
      vecs[6]  = '{8'hA8, 2'd2}; vecs[7]  = '{8'hAA, 2'd2}; vecs[8]  = '{8'hAC, 2'd2};
      vecs[9]  = '{8'h58, 2'd0}; vecs[10] = '{8'h00, 2'd3}; vecs[11] = '{8'h48, 2'd0};
      vecs[12] = '{8'h00, 2'd3}; vecs[13] = '{8'h58, 2'd0}; vecs[14] = '{8'h00, 2'd3};
      vecs[15] = '{8'h48, 2'd0}; vecs[16] = '{8'h00, 2'd3}; vecs[17] = '{8'h58, 2'd0};
      vecs[18] = '{8'h00, 2'd3}; vecs[19] = '{8'h48, 2'd0}; vecs[20] = '{8'h48, 2'd0};
      vecs[21] = '{8'h48, 2'd0}; vecs[22] = '{8'h1E, 2'd0};

      RSTn = 1'b0; En = 1'b0;
      tick(3);
      check("rst_bus_req", int'(bus_if.Bus_Req), 0);
      check("rst_bus_cmd", int'(bus_if.Bus_Cmd), 0);
      check("rst_bus_len", int'(bus_if.Bus_Rd_Len), 0);
      check("rst_dat_rdy", int'(Dat_Rdy), 0);
      check("rst_busy", int'(Busy), 0);
      check("rst_err", int'(Err), 0);
      check("rst_prom_valid", int'(Prom_Valid), 0);
      RSTn = 1'b1;
      tick(4);
      check("idle_no_req", int'(bus_if.Bus_Req) + req_log.size(), 0);

      // Init sequence with one A4 error, then two frames.
      err_cmd = 8'hA4; err_left = 1; cal_delay = 4;
      En = 1'b1;
      wait_reqs(17, 1500, "init_frames");
      for (int i = 0; i < 17; i++) check_req(i);
      if (done_log.size() >= 13 && ack_log.size() >= 10 && req_log.size() >= 14 && dat_log.size() >= 2) begin
         check("rst_wait_gap", req_log[1].cyc - done_log[0], 11);
         check("prom_datrdy_cyc", dat_log[0], done_log[8] + 1);
         check("d2_conv_gap", req_log[10].cyc - done_log[9], 21);
         check("frame_datrdy_cyc", dat_log[1], done_log[12] + 1);
         check("frame_period", req_log[13].cyc - ack_log[9], 100);
      end else begin
         check("init_logs_complete", 0, 1);
      end
      check("datrdy_count", dat_log.size(), 2);
      check("init_err", int'(Err), 0);
      check("init_prom_valid", int'(Prom_Valid), 1);

      // Retry exhaustion on the D1 convert command.
      err_cmd = 8'h48; err_left = 3;
      wait_reqs(23, 1000, "exhaust");
      for (int i = 17; i < 23; i++) check_req(i);
      check("exhaust_err", int'(Err), 1);
      check("exhaust_prom_valid", int'(Prom_Valid), 0);

      // Asynchronous reset in the middle of a transaction.
      for (int k = 0; k < 20 && !bus_if.Bus_Req; k++) tick(1);
      check("pre_reset_req", int'(bus_if.Bus_Req), 1);
      RSTn = 1'b0;
      #1;
      check("async_rst_req", int'(bus_if.Bus_Req), 0);
      check("async_rst_err", int'(Err), 0);
      check("async_rst_busy", int'(Busy), 0);
      tick(3);
      req_log.delete(); ack_log.delete(); done_log.delete(); dat_log.delete();
      err_left = 0; cal_delay = 14;
      RSTn = 1'b1;

      // Late Calib_Rdy: timeout sets Err after 8 cycles, frames keep running.
      wait_dat(2, 1000, "timeout_frame");
      if (dat_log.size() >= 2) begin
         while (cyc < dat_log[1] + 8) tick(1);
         check("cal_wait_err_before", int'(Err), 0);
         tick(1);
         check("cal_timeout_err", int'(Err), 1);
         $display("timeout: datrdy cyc=%0d err at cyc=%0d", dat_log[1], cyc);
      end
      cal_delay = 4;
      wait_reqs(15, 1000, "after_timeout");
      if (req_log.size() >= 15 && ack_log.size() >= 9) begin
         check("next_frame_cmd", int'(req_log[12].cmd), 8'h58);
         check("next_frame_period", req_log[12].cyc - ack_log[8], 100);
      end

      // Drop En during D1_WAIT: the frame finishes and the block goes idle.
      for (int k = 0; k < 50 && done_log.size() < 15; k++) tick(1);
      check("d1_done_seen", done_log.size() >= 15 ? 1 : 0, 1);
      tick(3);
      En = 1'b0;
      tick(300);
      check("en_off_req_count", req_log.size(), 16);
      if (req_log.size() >= 16) begin
         check("en_off_last_cmd", int'(req_log[15].cmd), 8'h00);
         check("en_off_last_len", int'(req_log[15].len), 3);
      end
      check("en_off_datrdy", dat_log.size(), 3);
      check("en_off_busy", int'(Busy), 0);
      check("en_off_req", int'(bus_if.Bus_Req), 0);
      check("err_sticky", int'(Err), 1);
      check("datrdy_req_overlap", overlap, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
